// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single registered memory request bus.
// Data wins over fetch, with a saturating starvation counter that forces a fetch grant.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [3:0]    m_be,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          busy
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [3:0]    m_be_q, m_be_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          sel_d_q, sel_d_d;
  logic          err_q, err_d;

  logic          d_mis;
  logic          fetch_forced;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wrep;
  logic          unused_bits;

  assign unused_bits = ^i_addr[1:0];

  // Size 11 behaves as a word for both alignment and lane selection.
  assign d_mis        = (d_size == 2'b01 && d_addr[0]) || (d_size[1] && d_addr[1:0] != 2'b00);
  assign fetch_forced = i_req && (starve_q == LIM);

  always_comb begin
    d_be   = 4'b1111;
    d_wrep = d_wdata;
    case (d_size)
      2'b00: begin
        d_be   = 4'b0001 << d_addr[1:0];
        d_wrep = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        d_be   = d_addr[1] ? 4'b1100 : 4'b0011;
        d_wrep = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    sel_d_d   = sel_d_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          sel_d_d = 1'b1;
          err_d   = d_mis;
          if (i_req && starve_q != LIM) starve_d = starve_q + 1'b1;
          if (d_mis) begin
            rdata_d = '0;
            state_d = RESP;
          end else begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = {d_addr[AW-1:2], 2'b00};
            m_wdata_d = d_wrep;
            state_d   = GNT_D;
          end
        end else if (i_req) begin
          sel_d_d   = 1'b0;
          err_d     = 1'b0;
          starve_d  = '0;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = 4'b1111;
          m_addr_d  = {i_addr[AW-1:2], 2'b00};
          state_d   = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          rdata_d = m_rdata;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'b0000;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      rdata_q   <= '0;
      sel_d_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
      sel_d_q   <= sel_d_d;
      err_q     <= err_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign busy    = (state_q != IDLE);
  assign i_ack   = (state_q == RESP) && !sel_d_q;
  assign d_ack   = (state_q == RESP) && sel_d_q;
  assign d_err   = d_ack && err_q;
  assign i_rdata = i_ack ? rdata_q : '0;
  assign d_rdata = d_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req, d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_ack, d_err;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ack, busy;

  int chk  = 0;
  int pass = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
  );

  task automatic wait_mreq(input string nm);
    int n = 0;
    @(negedge clk);
    while (m_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk++; if (m_req !== 1'b1) $display("FAIL %s_mreq_timeout got=%b exp=1", nm, m_req); else pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0;
    d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack = 0;
    repeat (3) @(negedge clk);
    chk++; if ({m_req, m_we, i_ack, d_ack, d_err, busy} !== 6'b0) $display("FAIL rst_ctl got=%b exp=000000", {m_req, m_we, i_ack, d_ack, d_err, busy}); else pass++;
    chk++; if (m_be !== 4'h0 || m_addr !== 0 || m_wdata !== 0) $display("FAIL rst_bus got be=%h addr=%h wd=%h exp=0", m_be, m_addr, m_wdata); else pass++;
    chk++; if (i_rdata !== 0 || d_rdata !== 0) $display("FAIL rst_rdata got i=%h d=%h exp=0", i_rdata, d_rdata); else pass++;
    rst_n = 1'b1;
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    m_ack = 1'b0;
    @(negedge clk);
    chk++; if ({i_ack, d_ack, busy, m_req} !== 4'b0) $display("FAIL idle_mack_ignored got=%b exp=0000", {i_ack, d_ack, busy, m_req}); else pass++;
  endtask

  task automatic test_fetch();
    i_addr = 32'h0000_0104; i_req = 1'b1;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || busy !== 1'b1) $display("FAIL fetch_c1_req got m_req=%b busy=%b exp=1", m_req, busy); else pass++;
    chk++; if (m_addr !== 32'h104 || m_be !== 4'hF || m_we !== 1'b0) $display("FAIL fetch_bus got addr=%h be=%h we=%b exp=104 f 0", m_addr, m_be, m_we); else pass++;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || m_addr !== 32'h104 || i_ack !== 1'b0) $display("FAIL fetch_c2_hold got m_req=%b addr=%h i_ack=%b", m_req, m_addr, i_ack); else pass++;
    m_ack = 1'b1; m_rdata = 32'h0050_0093;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    chk++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'h0050_0093) $display("FAIL fetch_c3_ack got i_ack=%b d_ack=%b rdata=%h exp=1 0 00500093", i_ack, d_ack, i_rdata); else pass++;
    chk++; if (m_req !== 1'b0) $display("FAIL fetch_c3_mreq got=%b exp=0", m_req); else pass++;
    i_req = 1'b0;
    @(negedge clk);
    chk++; if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 0) $display("FAIL fetch_c4_idle got i_ack=%b busy=%b rdata=%h", i_ack, busy, i_rdata); else pass++;
  endtask

  task automatic data_xact(input string nm, input logic we, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                           input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd);
    d_we = we; d_size = sz; d_addr = addr; d_wdata = wd; d_req = 1'b1;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || m_we !== we) $display("FAIL %s_req got m_req=%b we=%b exp=1 %b", nm, m_req, m_we, we); else pass++;
    chk++; if (m_addr !== e_addr || m_be !== e_be || m_wdata !== e_wd) $display("FAIL %s_bus got addr=%h be=%b wd=%h exp=%h %b %h", nm, m_addr, m_be, m_wdata, e_addr, e_be, e_wd); else pass++;
    m_ack = 1'b1; m_rdata = mem;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    chk++; if (d_ack !== 1'b1 || d_err !== 1'b0 || i_ack !== 1'b0 || d_rdata !== mem) $display("FAIL %s_ack got ack=%b err=%b i_ack=%b rdata=%h exp=1 0 0 %h", nm, d_ack, d_err, i_ack, d_rdata, mem); else pass++;
    d_req = 1'b0;
    @(negedge clk);
    chk++; if (d_ack !== 1'b0 || busy !== 1'b0) $display("FAIL %s_idle got ack=%b busy=%b exp=0 0", nm, d_ack, busy); else pass++;
  endtask

  task automatic test_data_sizes();
    data_xact("bstore", 1'b1, 2'b00, 32'h203, 32'h0000_00AB, 32'h1111_2222, 32'h200, 4'b1000, 32'hABAB_ABAB);
    data_xact("hstore", 1'b1, 2'b01, 32'h302, 32'h5555_1234, 32'h0, 32'h300, 4'b1100, 32'h1234_1234);
    data_xact("hload", 1'b0, 2'b01, 32'h310, 32'h0, 32'hCAFE_F00D, 32'h310, 4'b0011, 32'h0);
    data_xact("bload", 1'b0, 2'b00, 32'h321, 32'h0, 32'h8899_AABB, 32'h320, 4'b0010, 32'h0);
    data_xact("s11store", 1'b1, 2'b11, 32'h330, 32'h7654_3210, 32'h0, 32'h330, 4'b1111, 32'h7654_3210);
  endtask

  task automatic mis_xact(input string nm, input logic we, input logic [1:0] sz, input logic [31:0] addr);
    d_we = we; d_size = sz; d_addr = addr; d_wdata = 32'hFFFF_FFFF; d_req = 1'b1;
    m_rdata = 32'h9999_9999;
    @(negedge clk);
    chk++; if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) $display("FAIL %s_ack got ack=%b err=%b rdata=%h exp=1 1 0", nm, d_ack, d_err, d_rdata); else pass++;
    chk++; if (m_req !== 1'b0) $display("FAIL %s_nomreq got=%b exp=0", nm, m_req); else pass++;
    d_req = 1'b0;
    @(negedge clk);
    chk++; if (d_ack !== 1'b0 || m_req !== 1'b0 || busy !== 1'b0) $display("FAIL %s_after got ack=%b m_req=%b busy=%b", nm, d_ack, m_req, busy); else pass++;
    m_rdata = 32'h0;
  endtask

  task automatic test_misaligned();
    mis_xact("mis_hload", 1'b0, 2'b01, 32'h101);
    mis_xact("mis_wstore", 1'b1, 2'b10, 32'h102);
    mis_xact("mis_s11", 1'b0, 2'b11, 32'h101);
  endtask

  task automatic test_simultaneous();
    i_addr = 32'h300; i_req = 1'b1;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h500; d_req = 1'b1;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || m_addr !== 32'h500) $display("FAIL sim_dfirst got m_req=%b addr=%h exp=1 500", m_req, m_addr); else pass++;
    m_ack = 1'b1; m_rdata = 32'h0A0A_0A0A;
    @(negedge clk);
    m_ack = 1'b0;
    chk++; if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'h0A0A_0A0A) $display("FAIL sim_dack got d=%b i=%b rdata=%h", d_ack, i_ack, d_rdata); else pass++;
    d_req = 1'b0;
    @(negedge clk);
    chk++; if (m_req !== 1'b0 || busy !== 1'b0) $display("FAIL sim_gap got m_req=%b busy=%b exp=0 0", m_req, busy); else pass++;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || m_addr !== 32'h300 || m_we !== 1'b0) $display("FAIL sim_fetch got m_req=%b addr=%h we=%b", m_req, m_addr, m_we); else pass++;
    m_ack = 1'b1; m_rdata = 32'hB0B0_B0B0;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    chk++; if (i_ack !== 1'b1 || d_ack !== 1'b0 || i_rdata !== 32'hB0B0_B0B0) $display("FAIL sim_iack got i=%b d=%b rdata=%h", i_ack, d_ack, i_rdata); else pass++;
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic is_fetch, exp_fetch;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    i_addr = 32'h403; i_req = 1'b1;
    d_we = 1'b0; d_size = 2'b10; d_addr = 32'h800; d_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      wait_mreq("starve");
      is_fetch  = (m_addr == 32'h400);
      exp_fetch = (g == 4 || g == 9);
      chk++; if (is_fetch !== exp_fetch) $display("FAIL starve_grant%0d got fetch=%b addr=%h exp fetch=%b", g, is_fetch, m_addr, exp_fetch); else pass++;
      m_ack = 1'b1; m_rdata = 32'(g);
      @(negedge clk);
      m_ack = 1'b0;
      chk++; if (i_ack !== exp_fetch || d_ack !== !exp_fetch || d_err !== 1'b0) $display("FAIL starve_ack%0d got i=%b d=%b err=%b exp i=%b", g, i_ack, d_ack, d_err, exp_fetch); else pass++;
    end
    i_req = 1'b0; d_req = 1'b0; m_rdata = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_we = 1'b1; d_size = 2'b10; d_addr = 32'h600; d_wdata = 32'h1357_9BDF; d_req = 1'b1;
    @(negedge clk);
    chk++; if (m_req !== 1'b1 || m_we !== 1'b1) $display("FAIL rmid_grant got m_req=%b we=%b exp=1 1", m_req, m_we); else pass++;
    rst_n = 1'b0;
    @(negedge clk);
    chk++; if (m_req !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0) $display("FAIL rmid_abort got m_req=%b busy=%b d_ack=%b exp=0", m_req, busy, d_ack); else pass++;
    rst_n = 1'b1; d_req = 1'b0;
    m_ack = 1'b1; m_rdata = 32'h2468_ACE0;
    @(negedge clk);
    m_ack = 1'b0; m_rdata = 32'h0;
    chk++; if ({d_ack, i_ack, m_req, busy} !== 4'b0) $display("FAIL rmid_late1 got=%b exp=0000", {d_ack, i_ack, m_req, busy}); else pass++;
    @(negedge clk);
    chk++; if ({d_ack, i_ack, m_req, busy} !== 4'b0) $display("FAIL rmid_late2 got=%b exp=0000", {d_ack, i_ack, m_req, busy}); else pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_data_sizes();
    test_misaligned();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
